traffic_lamp_driver: RTL and testbench

- Downstream stage of traffic_control. Consumes the encoded light codes L_A/L_B and the pedestrian indicators RA/RB.
- Produces per-lamp drive enables for both approaches, with a shared flash generator for the FLASH_RED and FLASH_YELLOW codes.
- Monitors command integrity and lamp current-sense feedback. Raises a sticky ERR_OUT that is wired back to traffic_control's ERR input.

---
 rtl/traffic_pkg.sv | 58 +++++
 rtl/flash_gen.sv | 53 +++++
 rtl/traffic_lamp_driver.sv | 128 ++++++++++++
 tb/tb_traffic_lamp_driver.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared light-code, lamp-index and fault-code definitions for the
// traffic_control / traffic_lamp_driver pair.
package traffic_pkg;

   // Encoded light codes sent by traffic_control
   localparam logic [2:0] GREEN        = 3'b110;
   localparam logic [2:0] G_LEFT       = 3'b101;
   localparam logic [2:0] YELLOW       = 3'b100;
   localparam logic [2:0] RED          = 3'b011;
   localparam logic [2:0] G_RIGHT      = 3'b010;
   localparam logic [2:0] FLASH_RED    = 3'b111;
   localparam logic [2:0] FLASH_YELLOW = 3'b000;
   localparam logic [2:0] INVALID      = 3'b001;

   // Lamp enable bit positions, vector order {RIGHT,LEFT,GREEN,YELLOW,RED}
   localparam int LAMP_RED    = 0;
   localparam int LAMP_YELLOW = 1;
   localparam int LAMP_GREEN  = 2;
   localparam int LAMP_LEFT   = 3;
   localparam int LAMP_RIGHT  = 4;

   localparam logic [4:0] LAMP_STEADY_RED = 5'b00001;

   typedef enum logic [1:0] {
      FAULT_NONE     = 2'b00,
      FAULT_CONFLICT = 2'b01,
      FAULT_SENSE    = 2'b10,
      FAULT_INVALID  = 2'b11
   } fault_code_t;

   // Codes that need the shared flash phase (invalid falls back to flashing red)
   function automatic logic is_flash_code(input logic [2:0] code);
      return (code == FLASH_RED) || (code == FLASH_YELLOW) || (code == INVALID);
   endfunction

   // Light code to lamp enables; phase gates the flashing lamp
   function automatic logic [4:0] decode_lamp(input logic [2:0] code, input logic phase);
      logic [4:0] lamp;
      lamp = '0;
      case (code)
         GREEN:        lamp[LAMP_GREEN] = 1'b1;
         G_LEFT: begin
            lamp[LAMP_LEFT] = 1'b1;
            lamp[LAMP_RED]  = 1'b1;
         end
         YELLOW:       lamp[LAMP_YELLOW] = 1'b1;
         RED:          lamp[LAMP_RED] = 1'b1;
         G_RIGHT: begin
            lamp[LAMP_RIGHT] = 1'b1;
            lamp[LAMP_RED]   = 1'b1;
         end
         FLASH_YELLOW: lamp[LAMP_YELLOW] = phase;
         default:      lamp[LAMP_RED] = phase;
      endcase
      return lamp;
   endfunction

endpackage

// File: rtl/flash_gen.sv
// Shared flash phase generator. The phase seen by the decoder is forced
// "on" in the first cycle of a flash request so every flash episode
// starts with a full lamp-on half period.
module flash_gen #(
   parameter int FLASH_HALF = 4
) (
   input  logic CLK,
   input  logic reset_n,
   input  logic i_active,
   output logic o_phase
);

   localparam int CW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

   logic [CW-1:0] r_cnt;
   logic          r_phase;
   logic          r_active_d;

   logic          w_entry;
   logic [CW-1:0] w_cnt_eff;
   logic          w_phase_eff;
   logic          w_wrap;

   // A new flash episode restarts the half period with the lamp on
   assign w_entry     = i_active & ~r_active_d;
   assign w_cnt_eff   = w_entry ? '0 : r_cnt;
   assign w_phase_eff = w_entry ? 1'b1 : r_phase;
   assign w_wrap      = (w_cnt_eff == CW'(FLASH_HALF - 1));
   assign o_phase     = w_phase_eff;

   // Counter free-runs while flashing, toggling phase at each wrap
   always_ff @(posedge CLK) begin
      if (!reset_n) begin
         r_cnt      <= '0;
         r_phase    <= 1'b0;
         r_active_d <= 1'b0;
      end else if (!i_active) begin
         r_cnt      <= '0;
         r_phase    <= 1'b0;
         r_active_d <= 1'b0;
      end else begin
         r_active_d <= 1'b1;
         if (w_wrap) begin
            r_cnt   <= '0;
            r_phase <= ~w_phase_eff;
         end else begin
            r_cnt   <= w_cnt_eff + CW'(1);
            r_phase <= w_phase_eff;
         end
      end
   end

endmodule

// File: rtl/traffic_lamp_driver.sv
// Lamp driver downstream of traffic_control: decodes light codes into lamp
// enables, checks command integrity and lamp current sense, and latches a
// sticky fault that forces both approaches to flashing red.
module traffic_lamp_driver
   import traffic_pkg::*;
#(
   parameter int FLASH_HALF   = 4,
   parameter int FAULT_CYCLES = 4
) (
   input  logic       CLK,
   input  logic       reset_n,
   input  logic [2:0] L_A,
   input  logic [2:0] L_B,
   input  logic       RA,
   input  logic       RB,
   input  logic [4:0] SENSE_A,
   input  logic [4:0] SENSE_B,
   input  logic       ERR_CLR,
   output logic [4:0] LAMP_A,
   output logic [4:0] LAMP_B,
   output logic       WALK_A,
   output logic       WALK_B,
   output logic       ERR_OUT,
   output logic [1:0] FAULT_CODE
);

   localparam int MCW = $clog2(FAULT_CYCLES + 1);

   logic [4:0]  r_lamp_a, r_lamp_b;
   logic [4:0]  r_prev_a, r_prev_b;
   logic        r_walk_a, r_walk_b;
   logic        r_err;
   fault_code_t r_fault_code;
   logic [MCW-1:0] r_mis_cnt;

   logic        w_invalid, w_conflict, w_mismatch, w_sense_fault;
   logic        w_fault_any, w_err_next, w_flash_active, w_phase;
   fault_code_t w_cause;
   logic [4:0]  w_lamp_a_next, w_lamp_b_next;

   assign w_invalid  = (L_A == INVALID) || (L_B == INVALID);
   assign w_conflict = ((L_A == GREEN) && (L_B != RED)) ||
                       ((L_B == GREEN) && (L_A != RED)) ||
                       ((L_A == G_LEFT) && (L_B == G_LEFT));

   // Sense lags the drive by one cycle, so compare against last cycle's drive
   assign w_mismatch    = ({SENSE_A, SENSE_B} != {r_prev_a, r_prev_b});
   assign w_sense_fault = ~r_err & w_mismatch & (r_mis_cnt >= MCW'(FAULT_CYCLES - 1));

   // Highest-priority cause of this cycle's fault, if any
   always_comb begin
      w_cause     = FAULT_NONE;
      w_fault_any = 1'b1;
      if (w_invalid)          w_cause = FAULT_INVALID;
      else if (w_conflict)    w_cause = FAULT_CONFLICT;
      else if (w_sense_fault) w_cause = FAULT_SENSE;
      else                    w_fault_any = 1'b0;
   end

   // A new fault beats a same-cycle clear
   assign w_err_next     = w_fault_any | (r_err & ~ERR_CLR);
   assign w_flash_active = is_flash_code(L_A) | is_flash_code(L_B) | w_err_next;

   flash_gen #(
      .FLASH_HALF (FLASH_HALF)
   ) u_flash_gen (
      .CLK      (CLK),
      .reset_n  (reset_n),
      .i_active (w_flash_active),
      .o_phase  (w_phase)
   );

   assign w_lamp_a_next = w_err_next ? {4'b0000, w_phase} : decode_lamp(L_A, w_phase);
   assign w_lamp_b_next = w_err_next ? {4'b0000, w_phase} : decode_lamp(L_B, w_phase);

   // Registered lamp and walk drive, plus the one-cycle-old copy for sense
   always_ff @(posedge CLK) begin
      if (!reset_n) begin
         r_lamp_a <= LAMP_STEADY_RED;
         r_lamp_b <= LAMP_STEADY_RED;
         r_prev_a <= LAMP_STEADY_RED;
         r_prev_b <= LAMP_STEADY_RED;
         r_walk_a <= 1'b0;
         r_walk_b <= 1'b0;
      end else begin
         r_prev_a <= r_lamp_a;
         r_prev_b <= r_lamp_b;
         r_lamp_a <= w_lamp_a_next;
         r_lamp_b <= w_lamp_b_next;
         r_walk_a <= RA & ~w_err_next;
         r_walk_b <= RB & ~w_err_next;
      end
   end

   // Consecutive-mismatch counter, idle while a fault is latched
   always_ff @(posedge CLK) begin
      if (!reset_n || r_err) begin
         r_mis_cnt <= '0;
      end else if (w_mismatch) begin
         if (r_mis_cnt != MCW'(FAULT_CYCLES))
            r_mis_cnt <= r_mis_cnt + MCW'(1);
      end else begin
         r_mis_cnt <= '0;
      end
   end

   // Sticky fault latch keeping the first cause until cleared
   always_ff @(posedge CLK) begin
      if (!reset_n) begin
         r_err        <= 1'b0;
         r_fault_code <= FAULT_NONE;
      end else if (w_fault_any && (!r_err || ERR_CLR)) begin
         r_err        <= 1'b1;
         r_fault_code <= w_cause;
      end else if (ERR_CLR) begin
         r_err        <= 1'b0;
         r_fault_code <= FAULT_NONE;
      end
   end

   assign LAMP_A     = r_lamp_a;
   assign LAMP_B     = r_lamp_b;
   assign WALK_A     = r_walk_a;
   assign WALK_B     = r_walk_b;
   assign ERR_OUT    = r_err;
   assign FAULT_CODE = r_fault_code;

endmodule

// File: tb/tb_traffic_lamp_driver.sv
// Scenario bench for traffic_lamp_driver: each task builds a row table,
// pushes the expected outputs as each row is driven and compares them on
// the following falling edge.
module tb_traffic_lamp_driver;

   localparam logic [2:0] C_G = 3'b110, C_GL = 3'b101, C_Y = 3'b100, C_R = 3'b011;
   localparam logic [2:0] C_GR = 3'b010, C_FR = 3'b111, C_FY = 3'b000, C_INV = 3'b001;
   localparam logic [4:0] P_G = 5'b00100, P_GL = 5'b01001, P_Y = 5'b00010;
   localparam logic [4:0] P_R = 5'b00001, P_GR = 5'b10001, P_OFF = 5'b00000;
   localparam int HALF = 4;

   typedef struct packed {
      logic       rst_n;
      logic [2:0] la;
      logic [2:0] lb;
      logic       ra;
      logic       rb;
      logic       clr;
      logic [4:0] ma;
   } stim_t;

   logic       CLK = 1'b0;
   logic       reset_n;
   logic [2:0] L_A, L_B;
   logic       RA, RB, ERR_CLR;
   logic [4:0] SENSE_A, SENSE_B;
   logic [4:0] LAMP_A, LAMP_B;
   logic       WALK_A, WALK_B, ERR_OUT;
   logic [1:0] FAULT_CODE;

   logic [4:0] s_a, s_b, mask_a;
   logic [14:0] exp_q[$];
   int total = 0;
   int bad = 0;

   traffic_lamp_driver #(.FLASH_HALF(4), .FAULT_CYCLES(4)) dut (
      .CLK(CLK), .reset_n(reset_n), .L_A(L_A), .L_B(L_B), .RA(RA), .RB(RB),
      .SENSE_A(SENSE_A), .SENSE_B(SENSE_B), .ERR_CLR(ERR_CLR),
      .LAMP_A(LAMP_A), .LAMP_B(LAMP_B), .WALK_A(WALK_A), .WALK_B(WALK_B),
      .ERR_OUT(ERR_OUT), .FAULT_CODE(FAULT_CODE)
   );

   always #5 CLK = ~CLK;

   // Healthy lamps: sense reproduces the drive one cycle late
   always @(posedge CLK) begin
      s_a <= LAMP_A;
      s_b <= LAMP_B;
   end
   assign SENSE_A = s_a ^ mask_a;
   assign SENSE_B = s_b;

   function automatic stim_t st(input logic rst_n, input logic [2:0] la, input logic [2:0] lb,
                                input logic ra, input logic rb, input logic clr,
                                input logic [4:0] ma);
      return '{rst_n, la, lb, ra, rb, clr, ma};
   endfunction

   function automatic logic [14:0] pk(input logic [4:0] la, input logic [4:0] lb,
                                      input logic wa, input logic wb, input logic e,
                                      input logic [1:0] fc);
      return {la, lb, wa, wb, e, fc};
   endfunction

   function automatic logic fon(input int k);
      return ((k / HALF) % 2) == 0;
   endfunction

   task automatic apply(input stim_t s);
      reset_n = s.rst_n; L_A = s.la; L_B = s.lb; RA = s.ra; RB = s.rb;
      ERR_CLR = s.clr; mask_a = s.ma;
   endtask

   task automatic test_reset();
      stim_t sq[$];
      logic [14:0] eq[$];
      logic [14:0] o, e;
      for (int i = 0; i < 2; i++) begin
         sq.push_back(st(0, C_R, C_R, 1, 1, 0, 0)); eq.push_back(pk(P_R, P_R, 0, 0, 0, 2'b00));
      end
      sq.push_back(st(1, C_G, C_R, 0, 0, 0, 0)); eq.push_back(pk(P_G, P_R, 0, 0, 0, 2'b00));
      foreach (sq[i]) begin
         apply(sq[i]); exp_q.push_back(eq[i]);
         @(posedge CLK); @(negedge CLK);
         o = {LAMP_A, LAMP_B, WALK_A, WALK_B, ERR_OUT, FAULT_CODE}; e = exp_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL reset row %0d: got %b want %b", i, o, e); end
      end
   endtask

   task automatic test_decode();
      stim_t sq[$];
      logic [14:0] eq[$];
      logic [14:0] o, e;
      logic [2:0] codes[5];
      logic [4:0] pats[5];
      codes = '{C_G, C_GL, C_Y, C_R, C_GR};
      pats  = '{P_G, P_GL, P_Y, P_R, P_GR};
      for (int i = 0; i < 5; i++) begin
         sq.push_back(st(1, codes[i], C_R, 0, 0, 0, 0)); eq.push_back(pk(pats[i], P_R, 0, 0, 0, 2'b00));
      end
      for (int i = 0; i < 5; i++) begin
         sq.push_back(st(1, C_R, codes[i], 0, 0, 0, 0)); eq.push_back(pk(P_R, pats[i], 0, 0, 0, 2'b00));
      end
      foreach (sq[i]) begin
         apply(sq[i]); exp_q.push_back(eq[i]);
         @(posedge CLK); @(negedge CLK);
         o = {LAMP_A, LAMP_B, WALK_A, WALK_B, ERR_OUT, FAULT_CODE}; e = exp_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL decode row %0d: got %b want %b", i, o, e); end
      end
   endtask

   task automatic test_flash();
      stim_t sq[$];
      logic [14:0] eq[$];
      logic [14:0] o, e;
      for (int k = 0; k < 20; k++) begin
         sq.push_back(st(1, C_FY, C_FY, 0, 0, 0, 0));
         eq.push_back(pk({3'b000, fon(k), 1'b0}, {3'b000, fon(k), 1'b0}, 0, 0, 0, 2'b00));
      end
      sq.push_back(st(1, C_R, C_R, 0, 0, 0, 0)); eq.push_back(pk(P_R, P_R, 0, 0, 0, 2'b00));
      for (int k = 0; k < 10; k++) begin
         sq.push_back(st(1, C_FR, C_FR, 0, 0, 0, 0));
         eq.push_back(pk({4'b0000, fon(k)}, {4'b0000, fon(k)}, 0, 0, 0, 2'b00));
      end
      sq.push_back(st(1, C_R, C_R, 0, 0, 0, 0)); eq.push_back(pk(P_R, P_R, 0, 0, 0, 2'b00));
      for (int k = 0; k < 6; k++) begin
         sq.push_back(st(1, C_FY, C_R, 0, 0, 0, 0));
         eq.push_back(pk({3'b000, fon(k), 1'b0}, P_R, 0, 0, 0, 2'b00));
      end
      sq.push_back(st(1, C_R, C_R, 0, 0, 0, 0)); eq.push_back(pk(P_R, P_R, 0, 0, 0, 2'b00));
      foreach (sq[i]) begin
         apply(sq[i]); exp_q.push_back(eq[i]);
         @(posedge CLK); @(negedge CLK);
         o = {LAMP_A, LAMP_B, WALK_A, WALK_B, ERR_OUT, FAULT_CODE}; e = exp_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL flash row %0d: got %b want %b", i, o, e); end
      end
   endtask

   task automatic test_conflict();
      stim_t sq[$];
      logic [14:0] eq[$];
      logic [14:0] o, e;
      sq.push_back(st(1, C_G, C_GL, 0, 0, 0, 0)); eq.push_back(pk(P_R, P_R, 0, 0, 1, 2'b01));
      for (int k = 1; k < 6; k++) begin
         sq.push_back(st(1, C_R, C_R, 0, 0, 0, 0));
         eq.push_back(pk({4'b0000, fon(k)}, {4'b0000, fon(k)}, 0, 0, 1, 2'b01));
      end
      sq.push_back(st(1, C_R, C_R, 0, 0, 1, 0)); eq.push_back(pk(P_R, P_R, 0, 0, 0, 2'b00));
      sq.push_back(st(1, C_R, C_R, 0, 0, 0, 0)); eq.push_back(pk(P_R, P_R, 0, 0, 0, 2'b00));
      foreach (sq[i]) begin
         apply(sq[i]); exp_q.push_back(eq[i]);
         @(posedge CLK); @(negedge CLK);
         o = {LAMP_A, LAMP_B, WALK_A, WALK_B, ERR_OUT, FAULT_CODE}; e = exp_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL conflict row %0d: got %b want %b", i, o, e); end
      end
   endtask

   task automatic test_sense();
      stim_t sq[$];
      logic [14:0] eq[$];
      logic [14:0] o, e;
      for (int i = 0; i < 2; i++) begin
         sq.push_back(st(1, C_G, C_R, 0, 0, 0, 0)); eq.push_back(pk(P_G, P_R, 0, 0, 0, 2'b00));
      end
      for (int i = 0; i < 3; i++) begin
         sq.push_back(st(1, C_G, C_R, 0, 0, 0, 5'b00100)); eq.push_back(pk(P_G, P_R, 0, 0, 0, 2'b00));
      end
      sq.push_back(st(1, C_G, C_R, 0, 0, 0, 0)); eq.push_back(pk(P_G, P_R, 0, 0, 0, 2'b00));
      for (int i = 0; i < 3; i++) begin
         sq.push_back(st(1, C_G, C_R, 0, 0, 0, 5'b00100)); eq.push_back(pk(P_G, P_R, 0, 0, 0, 2'b00));
      end
      sq.push_back(st(1, C_G, C_R, 0, 0, 0, 5'b00100)); eq.push_back(pk(P_R, P_R, 0, 0, 1, 2'b10));
      sq.push_back(st(1, C_G, C_R, 0, 0, 1, 0)); eq.push_back(pk(P_G, P_R, 0, 0, 0, 2'b00));
      sq.push_back(st(1, C_G, C_R, 0, 0, 0, 0)); eq.push_back(pk(P_G, P_R, 0, 0, 0, 2'b00));
      foreach (sq[i]) begin
         apply(sq[i]); exp_q.push_back(eq[i]);
         @(posedge CLK); @(negedge CLK);
         o = {LAMP_A, LAMP_B, WALK_A, WALK_B, ERR_OUT, FAULT_CODE}; e = exp_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL sense row %0d: got %b want %b", i, o, e); end
      end
   endtask

   task automatic test_priority();
      stim_t sq[$];
      logic [14:0] eq[$];
      logic [14:0] o, e;
      sq.push_back(st(1, C_INV, C_G, 0, 0, 0, 0)); eq.push_back(pk(P_R, P_R, 0, 0, 1, 2'b11));
      sq.push_back(st(1, C_G, C_GL, 0, 0, 0, 0));  eq.push_back(pk(P_R, P_R, 0, 0, 1, 2'b11));
      sq.push_back(st(1, C_G, C_GL, 0, 0, 1, 0));  eq.push_back(pk(P_R, P_R, 0, 0, 1, 2'b01));
      sq.push_back(st(1, C_R, C_R, 0, 0, 1, 0));   eq.push_back(pk(P_R, P_R, 0, 0, 0, 2'b00));
      sq.push_back(st(1, C_R, C_R, 0, 0, 0, 0));   eq.push_back(pk(P_R, P_R, 0, 0, 0, 2'b00));
      foreach (sq[i]) begin
         apply(sq[i]); exp_q.push_back(eq[i]);
         @(posedge CLK); @(negedge CLK);
         o = {LAMP_A, LAMP_B, WALK_A, WALK_B, ERR_OUT, FAULT_CODE}; e = exp_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL priority row %0d: got %b want %b", i, o, e); end
      end
   endtask

   task automatic test_walk();
      stim_t sq[$];
      logic [14:0] eq[$];
      logic [14:0] o, e;
      sq.push_back(st(1, C_R, C_R, 1, 0, 0, 0)); eq.push_back(pk(P_R, P_R, 1, 0, 0, 2'b00));
      sq.push_back(st(1, C_R, C_R, 1, 1, 0, 0)); eq.push_back(pk(P_R, P_R, 1, 1, 0, 2'b00));
      sq.push_back(st(1, C_R, C_R, 1, 0, 0, 0)); eq.push_back(pk(P_R, P_R, 1, 0, 0, 2'b00));
      sq.push_back(st(1, C_R, C_R, 0, 0, 0, 0)); eq.push_back(pk(P_R, P_R, 0, 0, 0, 2'b00));
      sq.push_back(st(1, C_R, C_R, 0, 0, 0, 0)); eq.push_back(pk(P_R, P_R, 0, 0, 0, 2'b00));
      sq.push_back(st(1, C_GL, C_GL, 1, 0, 0, 0)); eq.push_back(pk(P_R, P_R, 0, 0, 1, 2'b01));
      for (int k = 1; k < 4; k++) begin
         sq.push_back(st(1, C_R, C_R, 1, 1, 0, 0)); eq.push_back(pk(P_R, P_R, 0, 0, 1, 2'b01));
      end
      sq.push_back(st(1, C_R, C_R, 0, 0, 1, 0)); eq.push_back(pk(P_R, P_R, 0, 0, 0, 2'b00));
      foreach (sq[i]) begin
         apply(sq[i]); exp_q.push_back(eq[i]);
         @(posedge CLK); @(negedge CLK);
         o = {LAMP_A, LAMP_B, WALK_A, WALK_B, ERR_OUT, FAULT_CODE}; e = exp_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL walk row %0d: got %b want %b", i, o, e); end
      end
   endtask

   task automatic test_reset_mid();
      stim_t sq[$];
      logic [14:0] eq[$];
      logic [14:0] o, e;
      sq.push_back(st(1, C_FY, C_FY, 0, 0, 0, 0)); eq.push_back(pk(P_Y, P_Y, 0, 0, 0, 2'b00));
      sq.push_back(st(1, C_FY, C_FY, 0, 0, 0, 0)); eq.push_back(pk(P_Y, P_Y, 0, 0, 0, 2'b00));
      sq.push_back(st(0, C_FY, C_FY, 1, 1, 0, 0)); eq.push_back(pk(P_R, P_R, 0, 0, 0, 2'b00));
      sq.push_back(st(1, C_GL, C_GL, 0, 0, 0, 0)); eq.push_back(pk(P_R, P_R, 0, 0, 1, 2'b01));
      sq.push_back(st(0, C_R, C_R, 0, 0, 0, 0));   eq.push_back(pk(P_R, P_R, 0, 0, 0, 2'b00));
      sq.push_back(st(1, C_R, C_R, 0, 0, 0, 0));   eq.push_back(pk(P_R, P_R, 0, 0, 0, 2'b00));
      sq.push_back(st(1, C_FY, C_FY, 0, 0, 0, 0)); eq.push_back(pk(P_Y, P_Y, 0, 0, 0, 2'b00));
      sq.push_back(st(1, C_R, C_R, 0, 0, 0, 0));   eq.push_back(pk(P_R, P_R, 0, 0, 0, 2'b00));
      foreach (sq[i]) begin
         apply(sq[i]); exp_q.push_back(eq[i]);
         @(posedge CLK); @(negedge CLK);
         o = {LAMP_A, LAMP_B, WALK_A, WALK_B, ERR_OUT, FAULT_CODE}; e = exp_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL reset_mid row %0d: got %b want %b", i, o, e); end
      end
   endtask

   initial begin
      apply(st(0, C_R, C_R, 0, 0, 0, 0));
      test_reset();
      test_decode();
      test_flash();
      test_conflict();
      test_sense();
      test_priority();
      test_walk();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
